// File: rtl/cntr_bs_dp_gen.sv
// cntr_bs_dp_gen: bank scheduler datapath for one bank.
// Holds RD_Q_NUM read queues and WR_Q_NUM write queues as circular buffers.
// Exports per-queue full/mid/empty, last pushed row address and head burst.
// Popped entries leave through a registered exit stage with a valid strobe.
// Optional macro CNTR_BS_DP_GEN_ERR_EN adds a sticky illegal-request flag 'err'.
module cntr_bs_dp_gen #(
    parameter int   RD_Q_NUM = 4,
    parameter int   WR_Q_NUM = 3,
    parameter int   RD_DEPTH = 4,
    parameter int   WR_DEPTH = 3,
    parameter int   MID_TH   = 2,
    parameter int   DQ       = 16,
    parameter int   IDX      = 7,
    parameter int   RA       = 16,
    parameter int   CA       = 10,
    parameter logic READ     = 1'b1,
    parameter logic WRITE    = 1'b0
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [RD_Q_NUM+WR_Q_NUM-1:0]                    push,
    input  logic [RD_Q_NUM+WR_Q_NUM-1:0]                    pop,
    input  logic [DQ-1:0]                                   dq_i,
    input  logic [IDX-1:0]                                  idx_i,
    input  logic [RA-1:0]                                   ra_i,
    input  logic [CA-1:0]                                   ca_i,
    output logic                                            grant,
    output logic [RD_Q_NUM+WR_Q_NUM-1:0]                    full,
    output logic [RD_Q_NUM+WR_Q_NUM-1:0]                    mid,
    output logic [RD_Q_NUM+WR_Q_NUM-1:0]                    empty,
    output logic [(RD_Q_NUM+WR_Q_NUM)*RA-1:0]               last_ra,
    output logic [(RD_Q_NUM+WR_Q_NUM)*(RA+CA-4)-1:0]        first_burst,
    output logic                                            out_valid,
    output logic [DQ-1:0]                                   dq_o,
    output logic [IDX-1:0]                                  idx_o,
    output logic [RA-1:0]                                   ra_o,
    output logic [CA-1:0]                                   ca_o,
    output logic                                            type_o
`ifdef CNTR_BS_DP_GEN_ERR_EN
    ,
    output logic                                            err
`endif
);

    localparam int Q     = RD_Q_NUM + WR_Q_NUM;
    localparam int BURST = RA + CA - 4;
    localparam int EW    = DQ + IDX + RA + CA;

    // True when exactly one bit of the request vector is set.
    function automatic logic onehot_f(input logic [Q-1:0] v);
        return (v != {Q{1'b0}}) && ((v & (v - {{(Q-1){1'b0}}, 1'b1})) == {Q{1'b0}});
    endfunction

    logic          push_oh_s;
    logic          pop_oh_s;
    logic          grant_s;
    logic          pop_eff_s;
    logic [Q-1:0]  full_s;
    logic [Q-1:0]  mid_s;
    logic [Q-1:0]  empty_s;
    logic          full_a_s   [Q];
    logic          mid_a_s    [Q];
    logic          empty_a_s  [Q];
    logic [RA-1:0] last_ra_a_s [Q];
    logic [EW-1:0] head_a_s   [Q];
    logic [EW-1:0] sel_entry_s;
    logic          sel_read_s;

    assign push_oh_s = onehot_f(push);
    assign pop_oh_s  = onehot_f(pop);
    // A same-cycle pop never frees space for the push: full uses the current count.
    assign grant_s   = push_oh_s && ((push & full_s) == {Q{1'b0}});
    assign pop_eff_s = pop_oh_s && ((pop & empty_s) == {Q{1'b0}});
    assign grant     = grant_s;

    for (genvar q = 0; q < Q; q++) begin : g_q
        localparam int D  = (q < RD_Q_NUM) ? RD_DEPTH : WR_DEPTH;
        localparam int CW = $clog2(D + 1);
        localparam int PW = $clog2(D);

        logic [EW-1:0] mem_r [D];
        logic [PW-1:0] wr_ptr_r;
        logic [PW-1:0] rd_ptr_r;
        logic [CW-1:0] cnt_r;
        logic [RA-1:0] last_ra_r;
        logic          push_q_s;
        logic          pop_q_s;
        logic [DQ-1:0] dq_w_s;

        assign push_q_s = grant_s && push[q];
        assign pop_q_s  = pop_eff_s && pop[q];
        // Read queues never carry write data.
        assign dq_w_s   = (q < RD_Q_NUM) ? {DQ{1'b0}} : dq_i;

        // Entry storage: written at the write pointer on an accepted push.
        always_ff @(posedge clk) begin
            if (push_q_s) begin
                mem_r[wr_ptr_r] <= {dq_w_s, idx_i, ra_i, ca_i};
            end
        end

        // Pointers, occupancy count and last pushed row address.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_r  <= {PW{1'b0}};
                rd_ptr_r  <= {PW{1'b0}};
                cnt_r     <= {CW{1'b0}};
                last_ra_r <= {RA{1'b0}};
            end else begin
                if (push_q_s) begin
                    wr_ptr_r  <= (wr_ptr_r == PW'(D - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
                    last_ra_r <= ra_i;
                end
                if (pop_q_s) begin
                    rd_ptr_r <= (rd_ptr_r == PW'(D - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
                end
                case ({push_q_s, pop_q_s})
                    2'b10:   cnt_r <= cnt_r + CW'(1);
                    2'b01:   cnt_r <= cnt_r - CW'(1);
                    default: cnt_r <= cnt_r;
                endcase
            end
        end

        assign full_a_s[q]    = (cnt_r == CW'(D));
        assign mid_a_s[q]     = (cnt_r >= CW'(MID_TH));
        assign empty_a_s[q]   = (cnt_r == {CW{1'b0}});
        assign last_ra_a_s[q] = last_ra_r;
        assign head_a_s[q]    = mem_r[rd_ptr_r];
    end

    // Pack per-queue status into the flat output vectors.
    always_comb begin
        full_s      = {Q{1'b0}};
        mid_s       = {Q{1'b0}};
        empty_s     = {Q{1'b0}};
        last_ra     = {(Q*RA){1'b0}};
        first_burst = {(Q*BURST){1'b0}};
        for (int i = 0; i < Q; i++) begin
            full_s[i]               = full_a_s[i];
            mid_s[i]                = mid_a_s[i];
            empty_s[i]              = empty_a_s[i];
            last_ra[i*RA +: RA]     = last_ra_a_s[i];
            if (empty_a_s[i]) begin
                first_burst[i*BURST +: BURST] = {BURST{1'b0}};
            end else begin
                first_burst[i*BURST +: BURST] = head_a_s[i][RA+CA-1:4];
            end
        end
    end

    assign full  = full_s;
    assign mid   = mid_s;
    assign empty = empty_s;

    // Exit mux: select the head of the popped queue (pop is one-hot when effective).
    always_comb begin
        sel_entry_s = {EW{1'b0}};
        for (int i = 0; i < Q; i++) begin
            if (pop[i]) begin
                sel_entry_s = sel_entry_s | head_a_s[i];
            end else begin
                sel_entry_s = sel_entry_s;
            end
        end
        sel_read_s = |pop[RD_Q_NUM-1:0];
    end

    // Exit stage: load on an effective pop, otherwise hold data and drop the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dq_o      <= {DQ{1'b0}};
            idx_o     <= {IDX{1'b0}};
            ra_o      <= {RA{1'b0}};
            ca_o      <= {CA{1'b0}};
            type_o    <= WRITE;
        end else if (pop_eff_s) begin
            out_valid <= 1'b1;
            dq_o      <= sel_read_s ? {DQ{1'b0}} : sel_entry_s[EW-1 -: DQ];
            idx_o     <= sel_entry_s[IDX+RA+CA-1 -: IDX];
            ra_o      <= sel_entry_s[RA+CA-1 -: RA];
            ca_o      <= sel_entry_s[CA-1:0];
            type_o    <= sel_read_s ? READ : WRITE;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef CNTR_BS_DP_GEN_ERR_EN
    logic bad_req_s;

    assign bad_req_s = ((push != {Q{1'b0}}) && !push_oh_s)
                    || (push_oh_s && ((push & full_s) != {Q{1'b0}}))
                    || ((pop != {Q{1'b0}}) && !pop_oh_s)
                    || (pop_oh_s && ((pop & empty_s) != {Q{1'b0}}));

    // Sticky illegal-request flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err | bad_req_s;
        end
    end
`endif

endmodule

// File: tb/tb_cntr_bs_dp_gen.sv
// Randomized bench for cntr_bs_dp_gen with a queue-based reference model.
module tb_cntr_bs_dp_gen;

    localparam int Q   = 7;
    localparam int RDQ = 4;
    localparam int BW  = 22;

    typedef struct packed {
        logic [15:0] dq;
        logic [6:0]  idx;
        logic [15:0] ra;
        logic [9:0]  ca;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    push = 7'd0;
    logic [6:0]    pop = 7'd0;
    logic [15:0]   dq_i = 16'd0;
    logic [6:0]    idx_i = 7'd0;
    logic [15:0]   ra_i = 16'd0;
    logic [9:0]    ca_i = 10'd0;
    logic          grant;
    logic [6:0]    full, mid, empty;
    logic [111:0]  last_ra;
    logic [153:0]  first_burst;
    logic          out_valid;
    logic [15:0]   dq_o;
    logic [6:0]    idx_o;
    logic [15:0]   ra_o;
    logic [9:0]    ca_o;
    logic          type_o;
`ifdef CNTR_BS_DP_GEN_ERR_EN
    logic          err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t        mq [Q][$];
    logic [15:0] m_last_ra [Q];
    logic        m_valid;
    logic [15:0] m_dq;
    logic [6:0]  m_idx;
    logic [15:0] m_ra;
    logic [9:0]  m_ca;
    logic        m_type;
    logic        m_err;

    cntr_bs_dp_gen dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .dq_i(dq_i), .idx_i(idx_i), .ra_i(ra_i), .ca_i(ca_i),
        .grant(grant), .full(full), .mid(mid), .empty(empty),
        .last_ra(last_ra), .first_burst(first_burst),
        .out_valid(out_valid), .dq_o(dq_o), .idx_o(idx_o),
        .ra_o(ra_o), .ca_o(ca_o), .type_o(type_o)
`ifdef CNTR_BS_DP_GEN_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dep(input int q);
        return (q < RDQ) ? 4 : 3;
    endfunction

    function automatic int oh_idx(input logic [6:0] v);
        int r = 0;
        for (int i = 0; i < Q; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < Q; i++) begin
            mq[i].delete();
            m_last_ra[i] = 16'd0;
        end
        m_valid = 1'b0; m_dq = 16'd0; m_idx = 7'd0; m_ra = 16'd0; m_ca = 10'd0;
        m_type = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_state();
        logic [6:0]   ef, em, ee;
        logic [111:0] elr;
        logic [153:0] efb;
        ef = 7'd0; em = 7'd0; ee = 7'd0; elr = '0; efb = '0;
        for (int i = 0; i < Q; i++) begin
            ef[i] = (mq[i].size() == dep(i));
            em[i] = (mq[i].size() >= 2);
            ee[i] = (mq[i].size() == 0);
            elr[i*16 +: 16] = m_last_ra[i];
            if (mq[i].size() > 0) efb[i*BW +: BW] = {mq[i][0].ra, mq[i][0].ca[9:4]};
        end
        check("full", full, ef);
        check("mid", mid, em);
        check("empty", empty, ee);
        check("last_ra", last_ra, elr);
        check("first_burst", first_burst, efb);
        check("out_valid", out_valid, m_valid);
        check("dq_o", dq_o, m_dq);
        check("idx_o", idx_o, m_idx);
        check("ra_o", ra_o, m_ra);
        check("ca_o", ca_o, m_ca);
        check("type_o", type_o, m_type);
`ifdef CNTR_BS_DP_GEN_ERR_EN
        check("err", err, m_err);
`endif
    endtask

    // Drive one cycle (called just after a falling edge), check grant, update model,
    // then check all outputs at the next falling edge.
    task automatic step(input logic [6:0] p, input logic [6:0] pp, input logic [15:0] d,
                        input logic [6:0] ix, input logic [15:0] r, input logic [9:0] c);
        int  pq, oq;
        logic g, pe;
        ent_t e;
        push = p; pop = pp; dq_i = d; idx_i = ix; ra_i = r; ca_i = c;
        #1;
        pq = oh_idx(p);
        oq = oh_idx(pp);
        g  = $onehot(p) && (mq[pq].size() < dep(pq));
        pe = $onehot(pp) && (mq[oq].size() > 0);
        check("grant", grant, g);
        if ((p != 7'd0 && !$onehot(p)) || ($onehot(p) && mq[pq].size() == dep(pq)) ||
            (pp != 7'd0 && !$onehot(pp)) || ($onehot(pp) && mq[oq].size() == 0))
            m_err = 1'b1;
        if (pe) begin
            e = mq[oq].pop_front();
            m_valid = 1'b1;
            m_dq   = (oq < RDQ) ? 16'd0 : e.dq;
            m_idx  = e.idx;
            m_ra   = e.ra;
            m_ca   = e.ca;
            m_type = (oq < RDQ) ? 1'b1 : 1'b0;
        end else begin
            m_valid = 1'b0;
        end
        if (g) begin
            mq[pq].push_back('{dq: d, idx: ix, ra: r, ca: c});
            m_last_ra[pq] = r;
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic rand_cycles(input int n);
        logic [6:0] p, pp;
        for (int i = 0; i < n; i++) begin
            int rp = $urandom_range(0, 9);
            int ro = $urandom_range(0, 9);
            int th = ((i / 40) % 2 == 0) ? 6 : 3;
            p  = (rp < th) ? (7'b1 << $urandom_range(0, 6)) :
                 (rp < 9) ? 7'd0 : 7'($urandom_range(0, 127));
            pp = (ro < 9 - th) ? (7'b1 << $urandom_range(0, 6)) :
                 (ro < 9) ? 7'd0 : 7'($urandom_range(0, 127));
            step(p, pp, 16'($urandom), 7'($urandom), 16'($urandom), 10'($urandom));
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_state();
        rst_n = 1'b1;
        @(negedge clk);

        // First push to queue 0
        step(7'b0000001, 7'd0, 16'hFFFF, 7'd5, 16'h1234, 10'h3F0);
        check("q0_last_ra", last_ra[15:0], 16'h1234);
        check("q0_first_burst", first_burst[21:0], 22'h048D3F);
        check("q0_empty", empty[0], 1'b0);

        // Fill queue 4 then overflow attempt
        step(7'b0010000, 7'd0, 16'h00A1, 7'd1, 16'h4001, 10'h011);
        step(7'b0010000, 7'd0, 16'h00A2, 7'd2, 16'h4002, 10'h022);
        check("q4_mid", mid[4], 1'b1);
        step(7'b0010000, 7'd0, 16'h00A3, 7'd3, 16'h4003, 10'h033);
        check("q4_full", full[4], 1'b1);
        step(7'b0010000, 7'd0, 16'h00A4, 7'd4, 16'h4004, 10'h044);

        // Drain queue 4 back-to-back
        step(7'd0, 7'b0010000, 16'd0, 7'd0, 16'd0, 10'd0);
        check("q4_pop1_dq", dq_o, 16'h00A1);
        step(7'd0, 7'b0010000, 16'd0, 7'd0, 16'd0, 10'd0);
        step(7'd0, 7'b0010000, 16'd0, 7'd0, 16'd0, 10'd0);
        check("q4_pop3_dq", dq_o, 16'h00A3);
        check("q4_empty", empty[4], 1'b1);

        // Queue 1 pointer wrap
        for (int k = 1; k <= 4; k++) step(7'b0000010, 7'd0, 16'hBEEF, 7'(k), 16'(k), 10'(k));
        repeat (2) step(7'd0, 7'b0000010, 16'd0, 7'd0, 16'd0, 10'd0);
        for (int k = 5; k <= 6; k++) step(7'b0000010, 7'd0, 16'hBEEF, 7'(k), 16'(k), 10'(k));
        for (int k = 3; k <= 6; k++) begin
            step(7'd0, 7'b0000010, 16'd0, 7'd0, 16'd0, 10'd0);
            check("q1_wrap_idx", idx_o, 7'(k));
            check("q1_wrap_dq", dq_o, 16'd0);
        end

        // Queue 2 simultaneous push/pop, empty then non-empty
        step(7'b0000100, 7'b0000100, 16'd0, 7'd21, 16'h2001, 10'h100);
        check("q2_nobypass_valid", out_valid, 1'b0);
        step(7'b0000100, 7'b0000100, 16'd0, 7'd22, 16'h2002, 10'h200);
        check("q2_pp_idx", idx_o, 7'd21);

        // Illegal multi-hot requests
        step(7'b0000110, 7'b0000011, 16'd0, 7'd0, 16'd0, 10'd0);
        check("multihot_valid", out_valid, 1'b0);

        rand_cycles(1500);

        // Asynchronous reset mid-traffic
        push = 7'b0001000; pop = 7'b0000001;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        @(negedge clk);
        check_state();
        push = 7'd0; pop = 7'd0;
        rst_n = 1'b1;
        step(7'd0, 7'd0, 16'd0, 7'd0, 16'd0, 10'd0);

        rand_cycles(800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
